// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared types, frame constants and CRC7 step for the SD CMD engine
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'b00,
    RESP_SHORT = 2'b01,
    RESP_LONG  = 2'b10
  } resp_mode_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } cmd_state_e;

  localparam int CMD_LEN   = 48;
  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;
  localparam int CRC_W     = 7;

  // x^7 + x^3 + 1 without the implicit x^7 term
  localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                 input logic din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
  endfunction

endpackage

// File: rtl/sd_cmd_host_param_if.sv
// rtl/sd_cmd_host_param_if.sv - request/response bundle between controller logic and the CMD engine
interface sd_cmd_host_param_if #(
  parameter int RESP_W = 134
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_index;
  logic [31:0]       cmd_arg;
  logic [1:0]        resp_mode;
  logic              crc_chk_en;
  logic              idx_chk_en;
  logic              busy;
  logic              done;
  logic [RESP_W-1:0] rsp_data;
  logic              err_timeout;
  logic              err_crc;
  logic              err_end;
  logic              err_index;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, resp_mode, crc_chk_en, idx_chk_en,
    input  cmd_ready, busy, done, rsp_data, err_timeout, err_crc, err_end, err_index
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, resp_mode, crc_chk_en, idx_chk_en,
    output cmd_ready, busy, done, rsp_data, err_timeout, err_crc, err_end, err_index
  );
endinterface

// File: rtl/sd_crc7_serial.sv
// rtl/sd_crc7_serial.sv - bit-serial CRC7 accumulator shared by command TX and response RX
module sd_crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [CRC_W-1:0] crc_o
);
  logic [CRC_W-1:0] crc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, din_i);
    end
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/sd_cmd_host_param.sv
// rtl/sd_cmd_host_param.sv - SD CMD line engine: init clocks, 48-bit command TX, R1/R2 RX, NCC gap
module sd_cmd_host_param
  import sd_cmd_pkg::*;
#(
  parameter int INIT_CYCLES = 64,
  parameter int NCR_MIN     = 2,
  parameter int NCR_TIMEOUT = 64,
  parameter int NCC_CYCLES  = 8,
  parameter int RESP_W      = 134
) (
  input  logic SD_CLK_IN,
  input  logic RST_IN,
  input  logic GO_IDLE,
  input  logic cmd_dat_i,
  output logic cmd_out_o,
  output logic cmd_oe_o,
  sd_cmd_host_param_if.slave bus
);
  localparam int CNT_W         = 16;
  localparam int SHORT_CRC_END = 39;
  localparam int LONG_CRC_BEG  = 8;
  localparam int LONG_CRC_END  = 127;

  cmd_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [5:0]        bit_q;
  logic [38:0]       tx_sh_q;
  logic [5:0]        index_q;
  logic              long_q, resp_q, crc_en_q, idx_en_q;
  logic              out_q, oe_q, ready_q, busy_q, done_q;
  logic [RESP_W-1:0] rsp_q;
  logic              err_to_q, err_crc_q, err_end_q, err_idx_q;

  logic             accept, start, crc_clr, crc_en, crc_din;
  logic [CRC_W-1:0] crc;
  logic [2:0]       crc_sel;
  logic [CNT_W-1:0] rx_last;

  assign accept  = (state_q == ST_IDLE) && bus.cmd_valid && ready_q;
  assign start   = (state_q == ST_WAIT) && !cmd_dat_i && (cnt_q >= CNT_W'(NCR_MIN));
  assign rx_last = long_q ? CNT_W'(LONG_LEN - 1) : CNT_W'(SHORT_LEN - 1);
  assign crc_sel = 3'(bit_q - 6'd2);

  // Start bits are 0, so a cleared register already holds their contribution.
  assign crc_clr = accept || start;
  always_comb begin
    crc_en = 1'b0;
    if (state_q == ST_TX) begin
      crc_en = (bit_q >= 6'd9);
    end else if (state_q == ST_RX) begin
      crc_en = long_q ? (cnt_q >= CNT_W'(LONG_CRC_BEG) && cnt_q <= CNT_W'(LONG_CRC_END))
                      : (cnt_q <= CNT_W'(SHORT_CRC_END));
    end
  end
  assign crc_din = (state_q == ST_TX) ? tx_sh_q[38] : cmd_dat_i;

  sd_crc7_serial u_crc (
    .clk_i (SD_CLK_IN),
    .rst_i (RST_IN),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (crc_din),
    .crc_o (crc)
  );

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      index_q   <= '0;
      long_q    <= 1'b0;
      resp_q    <= 1'b0;
      crc_en_q  <= 1'b0;
      idx_en_q  <= 1'b0;
      out_q     <= 1'b1;
      oe_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      rsp_q     <= '0;
      err_to_q  <= 1'b0;
      err_crc_q <= 1'b0;
      err_end_q <= 1'b0;
      err_idx_q <= 1'b0;
    end else if (GO_IDLE && state_q != ST_INIT) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_crc_q <= 1'b0;
      err_end_q <= 1'b0;
      err_idx_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (cnt_q >= CNT_W'(INIT_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_TX;
            bit_q     <= 6'(CMD_LEN - 1);
            tx_sh_q   <= {1'b1, bus.cmd_index, bus.cmd_arg};
            index_q   <= bus.cmd_index;
            resp_q    <= (bus.resp_mode != RESP_NONE);
            long_q    <= (bus.resp_mode == RESP_LONG);
            crc_en_q  <= bus.crc_chk_en;
            idx_en_q  <= bus.idx_chk_en;
            rsp_q     <= '0;
            err_to_q  <= 1'b0;
            err_crc_q <= 1'b0;
            err_end_q <= 1'b0;
            err_idx_q <= 1'b0;
            out_q     <= 1'b0;
            oe_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_TX: begin
          // bit_q is the frame bit on the line now; the register loads the next one.
          if (bit_q == 6'd0) begin
            out_q <= 1'b1;
            oe_q  <= 1'b0;
            cnt_q <= CNT_W'(1);
            if (resp_q) begin
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_GAP;
              done_q  <= (NCC_CYCLES == 1);
            end
          end else begin
            bit_q <= bit_q - 1'b1;
            if (bit_q >= 6'd9) begin
              out_q   <= tx_sh_q[38];
              tx_sh_q <= {tx_sh_q[37:0], 1'b0};
            end else if (bit_q >= 6'd2) begin
              out_q <= crc[crc_sel];
            end else begin
              out_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (start) begin
            state_q <= ST_RX;
            cnt_q   <= CNT_W'(1);
          end else if (cnt_q >= CNT_W'(NCR_TIMEOUT)) begin
            state_q  <= ST_GAP;
            cnt_q    <= CNT_W'(1);
            err_to_q <= 1'b1;
            done_q   <= (NCC_CYCLES == 1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RX: begin
          if (cnt_q == rx_last) begin
            // rsp_q[j] holds frame bit j+1, so CRC sits in [6:0] and the index in [44:39]
            err_end_q <= !cmd_dat_i;
            err_crc_q <= crc_en_q && (crc != rsp_q[CRC_W-1:0]);
            err_idx_q <= !long_q && idx_en_q && (rsp_q[44:39] != index_q);
            state_q   <= ST_GAP;
            cnt_q     <= CNT_W'(1);
            done_q    <= (NCC_CYCLES == 1);
          end else begin
            rsp_q <= {rsp_q[RESP_W-2:0], cmd_dat_i};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q >= CNT_W'(NCC_CYCLES)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == CNT_W'(NCC_CYCLES - 1));
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
          out_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_out_o       = out_q;
  assign cmd_oe_o        = oe_q;
  assign bus.cmd_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rsp_data    = rsp_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_crc     = err_crc_q;
  assign bus.err_end     = err_end_q;
  assign bus.err_index   = err_idx_q;
endmodule

// File: tb/tb_sd_cmd_host_param.sv
// tb/tb_sd_cmd_host_param.sv - randomized self-checking bench for sd_cmd_host_param
module tb_sd_cmd_host_param;
  localparam int INIT_C = 2;
  localparam int NCR_M  = 2;
  localparam int NCR_TO = 20;
  localparam int NCC    = 8;
  localparam int RW     = 134;

  logic clk = 1'b0;
  logic RST_IN, GO_IDLE, cmd_dat_i, cmd_out_o, cmd_oe_o;
  int total = 0;
  int bad = 0;

  sd_cmd_host_param_if #(.RESP_W(RW)) bus ();

  sd_cmd_host_param #(
    .INIT_CYCLES(INIT_C), .NCR_MIN(NCR_M), .NCR_TIMEOUT(NCR_TO),
    .NCC_CYCLES(NCC), .RESP_W(RW)
  ) dut (
    .SD_CLK_IN (clk),
    .RST_IN    (RST_IN),
    .GO_IDLE   (GO_IDLE),
    .cmd_dat_i (cmd_dat_i),
    .cmd_out_o (cmd_out_o),
    .cmd_oe_o  (cmd_oe_o),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_div(input logic [119:0] msg, input int nbits);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = nbits + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [3:0] errs();
    return {bus.err_timeout, bus.err_crc, bus.err_end, bus.err_index};
  endfunction

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] mode, input logic ce, input logic ie,
                         input logic respond, input int delay, input logic glitch,
                         input logic [135:0] rframe, output logic [47:0] tx_out);
    logic [39:0]  hdr;
    logic [47:0]  tx_exp, tx_got;
    logic [135:0] exp_rsp;
    logic [3:0]   exp_err;
    logic [6:0]   rcrc;
    logic         is_long, has_resp, oe_late, rdy;
    int           rlen, exp_off, got_off, oe_hi, j;

    hdr      = {2'b01, idx, arg};
    tx_exp   = {hdr, crc7_div(120'(hdr), 40), 1'b1};
    has_resp = (mode != 2'b00);
    is_long  = (mode == 2'b10);
    rlen     = is_long ? 136 : 48;
    exp_rsp  = '0;
    exp_err  = '0;
    if (!has_resp) begin
      exp_off = NCC;
    end else if (!respond) begin
      exp_off    = NCR_TO + NCC;
      exp_err[3] = 1'b1;
    end else begin
      exp_off = delay + rlen + NCC;
      if (is_long) begin
        exp_rsp = {2'b00, rframe[134:1]};
        rcrc    = crc7_div(rframe[127:8], 120);
      end else begin
        exp_rsp = {90'b0, rframe[46:1]};
        rcrc    = crc7_div(120'(rframe[47:8]), 40);
      end
      exp_err[2] = ce && (rcrc != rframe[7:1]);
      exp_err[1] = !rframe[0];
      exp_err[0] = !is_long && ie && (rframe[45:40] != idx);
    end

    rdy = 1'b0;
    for (int k = 0; k < 300 && !rdy; k++) begin
      if (bus.cmd_ready) rdy = 1'b1;
      else @(negedge clk);
    end
    check_val({tag, "/ready"}, 136'(rdy), 136'(1));
    check_val({tag, "/idle_oe"}, 136'(cmd_oe_o), 136'(0));

    bus.cmd_valid  = 1'b1;
    bus.cmd_index  = idx;
    bus.cmd_arg    = arg;
    bus.resp_mode  = mode;
    bus.crc_chk_en = ce;
    bus.idx_chk_en = ie;
    @(negedge clk);
    bus.cmd_valid = 1'b0;

    tx_got = '0;
    oe_hi  = 0;
    for (int i = 0; i < 48; i++) begin
      tx_got = {tx_got[46:0], cmd_out_o};
      if (cmd_oe_o) oe_hi++;
      if (i < 47) @(negedge clk);
    end
    tx_out = tx_got;
    check_val({tag, "/tx_frame"}, 136'(tx_got), 136'(tx_exp));
    check_val({tag, "/tx_oe_cycles"}, 136'(oe_hi), 136'(48));

    got_off = -1;
    oe_late = 1'b0;
    for (int c = 1; c <= 400 && got_off < 0; c++) begin
      @(negedge clk);
      if (bus.done) got_off = c;
      if (cmd_oe_o) oe_late = 1'b1;
      j = c - 1;
      if (respond && has_resp && j < delay) cmd_dat_i = !(glitch && j == 0);
      else if (respond && has_resp && j - delay < rlen) cmd_dat_i = rframe[rlen - 1 - (j - delay)];
      else cmd_dat_i = 1'b1;
    end
    cmd_dat_i = 1'b1;
    check_val({tag, "/done_cycle"}, 136'(got_off), 136'(exp_off));
    check_val({tag, "/oe_after_tx"}, 136'(oe_late), 136'(0));
    check_val({tag, "/rsp_data"}, 136'(bus.rsp_data), exp_rsp);
    check_val({tag, "/errors"}, 136'(errs()), 136'(exp_err));

    @(negedge clk);
    check_val({tag, "/done_width"}, 136'(bus.done), 136'(0));
    check_val({tag, "/ready_after"}, 136'(bus.cmd_ready), 136'(1));
    check_val({tag, "/errors_hold"}, 136'(errs()), 136'(exp_err));
  endtask

  initial begin
    logic [47:0]  txo;
    logic [135:0] rf;
    logic [127:0] rnd;
    logic [119:0] body;
    logic [5:0]   ridx, idx;
    logic [31:0]  arg;
    logic [1:0]   mode;
    logic         ce, ie, resp, gl;
    logic [6:0]   flip;
    int           dly, init_len;

    RST_IN = 1'b1;
    GO_IDLE = 1'b0;
    cmd_dat_i = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg = '0;
    bus.resp_mode = '0;
    bus.crc_chk_en = 1'b0;
    bus.idx_chk_en = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst/busy", 136'(bus.busy), 136'(1));
    check_val("rst/cmd", 136'({cmd_out_o, cmd_oe_o}), 136'(2'b11));
    check_val("rst/ready_done", 136'({bus.cmd_ready, bus.done}), 136'(0));
    check_val("rst/rsp", 136'(bus.rsp_data), 136'(0));
    check_val("rst/errs", 136'(errs()), 136'(0));

    RST_IN = 1'b0;
    init_len = -1;
    for (int k = 1; k <= 20 && init_len < 0; k++) begin
      @(negedge clk);
      if (k == 1) check_val("init/oe", 136'(cmd_oe_o), 136'(1));
      if (bus.cmd_ready) init_len = k;
    end
    check_val("init/len", 136'(init_len), 136'(INIT_C));
    check_val("init/idle_oe_busy", 136'({cmd_oe_o, bus.busy}), 136'(0));

    run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, txo);
    check_val("cmd0/const", 136'(txo), 136'(48'h400000000095));

    rf = 136'(48'h08000001AA13);
    run_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b1, 4, 1'b0, rf, txo);
    check_val("cmd8/const", 136'(txo), 136'(48'h48000001AA87));

    rf = 136'(48'h08000001AA13 ^ 48'h1 << 20);
    run_cmd("cmd8_flip_chk", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b1, 4, 1'b0, rf, txo);
    run_cmd("cmd8_flip_nochk", 6'd8, 32'h1AA, 2'b01, 1'b0, 1'b1, 1'b1, 4, 1'b0, rf, txo);

    run_cmd("timeout", 6'd13, 32'h5555_0000, 2'b01, 1'b1, 1'b1, 1'b0, 0, 1'b0, '0, txo);

    bus.cmd_valid = 1'b1;
    bus.cmd_index = 6'd17;
    bus.cmd_arg = 32'hDEAD_BEEF;
    bus.resp_mode = 2'b01;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (27) @(negedge clk);
    GO_IDLE = 1'b1;
    @(negedge clk);
    GO_IDLE = 1'b0;
    check_val("abort/oe_out", 136'({cmd_oe_o, cmd_out_o}), 136'(2'b01));
    check_val("abort/ready_busy_done", 136'({bus.cmd_ready, bus.busy, bus.done}), 136'(3'b100));
    check_val("abort/errs", 136'(errs()), 136'(0));
    run_cmd("cmd0_after_abort", 6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, txo);

    rf = 136'(48'h08000001AA13);
    run_cmd("glitch", 6'd8, 32'h1AA, 2'b01, 1'b1, 1'b1, 1'b1, 3, 1'b1, rf, txo);

    rnd = {$urandom, $urandom, $urandom, $urandom};
    body = rnd[119:0];
    rf = {2'b00, 6'h3F, body, crc7_div(body, 120), 1'b0};
    run_cmd("cmd2_long", 6'd2, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 2, 1'b0, rf, txo);

    for (int n = 0; n < 8; n++) begin
      idx  = 6'($urandom);
      arg  = $urandom;
      mode = 2'($urandom_range(0, 3));
      ce   = 1'($urandom_range(0, 1));
      ie   = 1'($urandom_range(0, 1));
      resp = ($urandom_range(0, 5) != 0);
      dly  = int'($urandom_range(NCR_M - 1, 10));
      gl   = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 2) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h0;
      if (mode == 2'b10) begin
        rnd  = {$urandom, $urandom, $urandom, $urandom};
        body = rnd[119:0];
        rf   = {2'b00, 6'h3F, body, crc7_div(body, 120) ^ flip, 1'($urandom_range(0, 3) != 0)};
      end else begin
        ridx = ($urandom_range(0, 2) == 0) ? 6'($urandom) : idx;
        rf   = 136'({2'b00, ridx, 32'($urandom)});
        rf   = 136'({rf[39:0], crc7_div(120'(rf[39:0]), 40) ^ flip, 1'($urandom_range(0, 3) != 0)});
      end
      run_cmd($sformatf("rand%0d", n), idx, arg, mode, ce, ie, resp, dly, gl, rf, txo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
